// File: rtl/adc_delay_scan.sv
// rtl/adc_delay_scan.sv - ADC input-delay calibration sequencer for one channel
//
// Scans the IODELAY tap 0..NTAPS-1. At each tap it loads the tap, waits for
// the delay to settle, then opens a pattern-check window. It then centres on
// the longest contiguous run of error-free taps.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   start       rising edge requests a scan (ignored while busy)
//   cntmax      window length select, window = 2**(WBASE + 2*cntmax) cycles
//   err         pattern-checker error, only looked at while check_en=1
//   tap/tap_ld  delay tap value and its one-cycle load strobe
//   check_en    high for the whole check window
//   busy, done  scan in progress / one-cycle end-of-scan pulse
//   fail        no tap passed
//   best_tap    selected centre tap
//   best_len    length of the best passing run
module adc_delay_scan #(
  parameter int NTAPS  = 32,
  parameter int WBASE  = 16,
  parameter int SETTLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] cntmax,
  input  logic       err,
  output logic [4:0] tap,
  output logic       tap_ld,
  output logic       check_en,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [4:0] best_tap,
  output logic [5:0] best_len
);

  // Wide enough for the longest window, 2**(WBASE+14).
  localparam int CW = WBASE + 15;
  localparam logic [4:0] LAST_TAP = 5'(NTAPS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_WINDOW, S_EVAL, S_FINISH} state_t;

  state_t        state_q, state_d;
  logic          start_d_q;
  logic [4:0]    tap_q, tap_d;
  logic          busy_q, busy_d;
  logic          fail_q, fail_d;
  logic [4:0]    best_tap_q, best_tap_d;
  logic [5:0]    best_len_q, best_len_d;
  logic [31:0]   bitmap_q, bitmap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    cntmax_q, cntmax_d;
  logic          tap_bad_q, tap_bad_d;
  logic [4:0]    idx_q, idx_d;
  logic [4:0]    run_start_q, run_start_d;
  logic [5:0]    run_len_q, run_len_d;
  logic [5:0]    bl_q, bl_d;   // best run length found so far during EVAL
  logic [4:0]    bs_q, bs_d;   // start of that run

  logic       accept;
  logic [5:0] shamt;
  logic [5:0] nlen;
  logic [4:0] nstart;
  logic [5:0] half;

  assign accept = start & ~start_d_q & (state_q == S_IDLE);
  assign shamt  = 6'(WBASE) + {2'b00, cntmax_q, 1'b0};

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    busy_d      = busy_q;
    fail_d      = fail_q;
    best_tap_d  = best_tap_q;
    best_len_d  = best_len_q;
    bitmap_d    = bitmap_q;
    cnt_d       = cnt_q;
    cntmax_d    = cntmax_q;
    tap_bad_d   = tap_bad_q;
    idx_d       = idx_q;
    run_start_d = run_start_q;
    run_len_d   = run_len_q;
    bl_d        = bl_q;
    bs_d        = bs_q;
    nlen        = '0;
    nstart      = '0;
    half        = '0;
    tap_ld      = 1'b0;
    check_en    = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tap_d      = '0;
          busy_d     = 1'b1;
          fail_d     = 1'b0;
          best_len_d = '0;
          best_tap_d = '0;
          bitmap_d   = '0;
          cntmax_d   = cntmax;
          tap_bad_d  = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        tap_ld  = 1'b1;
        cnt_d   = CW'(SETTLE);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = CW'(1) << shamt;
          state_d = S_WINDOW;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WINDOW: begin
        check_en = 1'b1;
        if (cnt_q == CW'(1)) begin
          // The last window cycle's err still counts against this tap.
          bitmap_d[tap_q] = ~(tap_bad_q | err);
          tap_bad_d       = 1'b0;
          if (tap_q == LAST_TAP) begin
            idx_d       = '0;
            run_len_d   = '0;
            run_start_d = '0;
            bl_d        = '0;
            bs_d        = '0;
            state_d     = S_EVAL;
          end else begin
            tap_d   = tap_q + 5'd1;
            state_d = S_LOAD;
          end
        end else begin
          tap_bad_d = tap_bad_q | err;
          cnt_d     = cnt_q - CW'(1);
        end
      end
      S_EVAL: begin
        if (bitmap_q[idx_q]) begin
          nlen        = run_len_q + 6'd1;
          nstart      = (run_len_q == 6'd0) ? idx_q : run_start_q;
          run_len_d   = nlen;
          run_start_d = nstart;
          // Strictly longer only: on ties the lower-index run is kept.
          if (nlen > bl_q) begin
            bl_d = nlen;
            bs_d = nstart;
          end
        end else begin
          run_len_d = '0;
        end
        if (idx_q == LAST_TAP) begin
          // Final result is registered here so it is already on tap when
          // FINISH strobes tap_ld and done.
          if (bl_d != 6'd0) begin
            half       = (bl_d - 6'd1) >> 1;
            best_len_d = bl_d;
            best_tap_d = bs_d + half[4:0];
            fail_d     = 1'b0;
          end else begin
            best_len_d = '0;
            best_tap_d = '0;
            fail_d     = 1'b1;
          end
          tap_d   = best_tap_d;
          state_d = S_FINISH;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_FINISH: begin
        tap_ld  = 1'b1;
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_d_q   <= 1'b0;
      tap_q       <= '0;
      busy_q      <= 1'b0;
      fail_q      <= 1'b0;
      best_tap_q  <= '0;
      best_len_q  <= '0;
      bitmap_q    <= '0;
      cnt_q       <= '0;
      cntmax_q    <= '0;
      tap_bad_q   <= 1'b0;
      idx_q       <= '0;
      run_start_q <= '0;
      run_len_q   <= '0;
      bl_q        <= '0;
      bs_q        <= '0;
    end else begin
      state_q     <= state_d;
      start_d_q   <= start;
      tap_q       <= tap_d;
      busy_q      <= busy_d;
      fail_q      <= fail_d;
      best_tap_q  <= best_tap_d;
      best_len_q  <= best_len_d;
      bitmap_q    <= bitmap_d;
      cnt_q       <= cnt_d;
      cntmax_q    <= cntmax_d;
      tap_bad_q   <= tap_bad_d;
      idx_q       <= idx_d;
      run_start_q <= run_start_d;
      run_len_q   <= run_len_d;
      bl_q        <= bl_d;
      bs_q        <= bs_d;
    end
  end

  assign tap      = tap_q;
  assign busy     = busy_q;
  assign fail     = fail_q;
  assign best_tap = best_tap_q;
  assign best_len = best_len_q;

endmodule

// File: tb/tb_adc_delay_scan.sv
// tb/tb_adc_delay_scan.sv - self-checking bench for adc_delay_scan
module tb_adc_delay_scan;

  localparam int NTAPS  = 32;
  localparam int WBASE  = 2;
  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] cntmax = 3'd0;
  logic       err = 1'b0;
  logic [4:0] tap;
  logic       tap_ld;
  logic       check_en;
  logic       busy;
  logic       done;
  logic       fail;
  logic [4:0] best_tap;
  logic [5:0] best_len;

  int tests = 0;
  int fails = 0;

  adc_delay_scan #(.NTAPS(NTAPS), .WBASE(WBASE), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cntmax(cntmax), .err(err),
    .tap(tap), .tap_ld(tap_ld), .check_en(check_en), .busy(busy), .done(done),
    .fail(fail), .best_tap(best_tap), .best_len(best_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Longest run of passing taps, lowest index on ties, centre rounded down.
  task automatic model(input logic [31:0] pat, output int blen, output int btap);
    int run;
    int bs;
    run = 0; bs = 0; blen = 0;
    for (int i = 0; i < NTAPS; i++) begin
      if (pat[i]) begin
        run++;
        if (run > blen) begin
          blen = run;
          bs = i - run + 1;
        end
      end else begin
        run = 0;
      end
    end
    btap = (blen > 0) ? bs + (blen - 1) / 2 : 0;
  endtask

  // pat[i]=1 means tap i passes; failing taps get at least one err in-window.
  task automatic run_scan(input logic [31:0] pat, input logic [2:0] cm, input bit noise,
                          input bit midstart, input int abort_tap);
    int cyc, c0, nld, wlen, w, pos, exp_len, exp_tap, lat;
    logic [4:0] exp_next;
    bit prev_ce, got_done;
    w = 1 << (WBASE + 2 * int'(cm));
    lat = NTAPS * (1 + SETTLE + w) + NTAPS + 1;
    model(pat, exp_len, exp_tap);
    @(negedge clk);
    cntmax = cm; start = 1'b1; err = 1'b0;
    cyc = 0; c0 = -1; nld = 0; wlen = 0; prev_ce = 1'b0; exp_next = '0; got_done = 1'b0;
    pos = $urandom_range(w - 1, 0);
    while (!got_done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (midstart && cyc == 1000) start = 1'b1;
      if (midstart && cyc == 1010) start = 1'b0;
      if (tap_ld && !done) begin
        if (c0 < 0) c0 = cyc;
        chk("tap_seq", int'(tap), int'(exp_next));
        exp_next = exp_next + 5'd1;
        nld++;
      end
      if (check_en) begin
        wlen++;
      end else if (prev_ce) begin
        chk("win_len", wlen, w);
        wlen = 0;
        pos = $urandom_range(w - 1, 0);
      end
      prev_ce = check_en;
      if (check_en)
        err = !pat[tap] && (wlen == pos + 1 || $urandom_range(3, 0) == 0);
      else
        err = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      if (abort_tap >= 0 && check_en && int'(tap) == abort_tap && wlen == 2) begin
        rst_n = 1'b0;
        #2;
        chk("abort_outputs", int'({tap, tap_ld, check_en, busy, done, fail, best_tap, best_len}), 0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("abort_quiet", int'({done, busy, tap_ld, check_en}), 0);
        end
        err = 1'b0;
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        got_done = 1'b1;
        chk("latency", cyc - c0 + 1, lat);
        chk("n_loads", nld, NTAPS);
        chk("best_len", int'(best_len), exp_len);
        chk("best_tap", int'(best_tap), exp_tap);
        chk("fail", int'(fail), (exp_len == 0) ? 1 : 0);
        chk("final_tap", int'(tap), exp_tap);
        chk("final_ld", int'(tap_ld), 1);
      end
    end
    if (!got_done) chk("timeout", 0, 1);
    err = 1'b0;
    @(negedge clk);
    chk("idle_after", int'({busy, done, tap_ld, check_en}), 0);
    chk("held_len", int'(best_len), exp_len);
  endtask

  initial begin
    logic [31:0] pat;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({tap, tap_ld, check_en, busy, done, fail, best_tap, best_len}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_scan(32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0, -1);
    run_scan(32'h000F_FC00, 3'd0, 1'b1, 1'b0, -1);
    run_scan(32'h0000_F078, 3'd0, 1'b0, 1'b0, -1);
    run_scan(32'h0000_0000, 3'd0, 1'b1, 1'b0, -1);
    run_scan(32'hFFFF_FFFF, 3'd2, 1'b1, 1'b1, -1);
    run_scan(32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0, 7);
    run_scan(32'h7FFF_FFFE, 3'd0, 1'b0, 1'b0, -1);
    for (int r = 0; r < 4; r++) begin
      pat = $urandom();
      if (r == 0) pat = pat | 32'h8000_0001;
      run_scan(pat, 3'($urandom_range(1, 0)), 1'b1, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_delay_scan.md
Name: adc_delay_scan

Overview:
- Automatic ADC input-delay calibration sequencer for one channel.
- Steps the input delay tap from 0 to NTAPS-1. At each tap it waits for the delay to settle, then opens a test-pattern check window and records whether the pattern checker reported any error.
- Afterwards it finds the longest contiguous run of error-free taps, loads the centre tap and reports it. Sits between the control-register interface and the channel's IODELAY / pattern checker.

Parameters:
- NTAPS, 32, number of delay taps scanned (2..32); tap width is 5 bits.
- WBASE, 16, log2 of minimum window length in clk periods; the bench overrides it to 2.
- SETTLE, 16, clk periods waited after each tap load before the window opens (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  scan request; rising edge starts a scan
- cntmax  in  3  window length select; window = 2**(WBASE + 2*cntmax) clk periods
- err  in  1  pattern-checker error; sampled only while check_en=1
- tap  out  5  delay tap value to IODELAY
- tap_ld  out  1  one-cycle load strobe for tap
- check_en  out  1  high for the whole check window
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at scan end
- fail  out  1  high when no tap passed; held until next accepted start
- best_tap  out  5  selected tap; held until next accepted start
- best_len  out  6  length of best passing run (0..32); held until next accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, pass bitmap 0, start_d 0, counters 0. Reset mid-scan aborts immediately; no done pulse is produced.
- Start detection:
  - start is registered (start_d); accept = start & !start_d & state==IDLE.
  - Edges while busy are ignored and not queued.
  - cntmax is latched at accept.
- IDLE: on accept, tap<=0, busy<=1, fail<=0, best_len<=0, best_tap<=0, bitmap<=0, then go to LOAD.
- LOAD (1 cycle): tap_ld=1, then go to SETTLE with counter=SETTLE.
- SETTLE: decrement each cycle; when counter reaches 1, go to WINDOW with counter=2**(WBASE+2*cntmax_latched).
  - Counter width is WBASE+15 bits; no overflow for cntmax=7.
- WINDOW:
  - check_en=1 for exactly 2**(WBASE+2*cntmax) cycles.
  - Any err=1 in those cycles sets tap_bad. err outside windows is ignored.
  - At window end: bitmap[tap] <= !tap_bad, clear tap_bad.
  - If tap==NTAPS-1, go to EVAL; else tap<=tap+1 and go to LOAD.
- EVAL: one bitmap bit per cycle, i=0..NTAPS-1, NTAPS cycles.
  - Tracks run_start and run_len.
  - A run replaces the best only if strictly longer, so on ties the lowest-index run wins.
  - No wrap-around between tap NTAPS-1 and tap 0.
- FINISH (1 cycle):
  - If best run length > 0: best_tap = run_start + (len-1)>>1 (lower centre for even lengths), best_len = len, fail = 0.
  - Otherwise best_tap = 0, best_len = 0, fail = 1.
  - Drive tap<=best_tap with tap_ld=1 the same cycle, done=1, busy<=0, go to IDLE.
- Latency from accept to done: NTAPS*(1 + SETTLE + W) + NTAPS + 1 cycles (W = window length), measured from the cycle after the start edge is registered.
- tap holds its last loaded value while IDLE.
- check_en, tap_ld and done are never asserted while busy=0, except for the FINISH cycle.

Test Plan:
- WBASE=2, SETTLE=4, NTAPS=32, cntmax=0, err never asserted -> 32 tap_ld pulses with tap 0..31, each window exactly 4 cycles; done, best_len=32, best_tap=15, fail=0, final tap=15.
- err asserted only during windows of taps 0-9 and 20-31 -> best_len=10, best_tap=14.
- Two equal passing runs, taps 3-6 and 12-15 -> best_len=4, best_tap=4 (earlier run wins).
- err held high throughout -> fail=1, best_len=0, best_tap=0, final tap=0 with tap_ld.
- cntmax=2 -> each check_en window is 64 cycles; total scan 32*(1+4+64)+33 = 2241 cycles after accept; a start edge mid-scan changes nothing.
- rst_n low during WINDOW of tap 7 -> all outputs 0 asynchronously, no done pulse; after release a new start produces a full scan.
